weight_tile_loader: RTL and testbench

- Upstream feeder for the weight arranger stage of the systolic array.
- Assembles N*N-byte weight tiles from a narrow valid/ready byte-lane stream into two ping-pong tile buffers.
- Sequences each full tile into the arranger: a one-cycle weight_en load pulse, then weight_ctr held for N cycles while the arranger emits columns.
- Decouples memory-side fetch rate from array-side consumption.

---
 rtl/weight_tile_loader_if.sv | 21 ++
 rtl/weight_tile_loader.sv | 152 +++++++++++++++
 tb/tb_weight_tile_loader.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/weight_tile_loader_if.sv
// Byte-lane input stream into weight_tile_loader.
// Ports: in_valid/in_data from source, in_ready back to source.
interface weight_tile_loader_if #(
    parameter int BUS_BYTES = 4
) ();
    logic                   in_valid;
    logic                   in_ready;
    logic [8*BUS_BYTES-1:0] in_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/weight_tile_loader.sv
// Ping-pong N*N-byte weight tile assembler feeding the weight arranger.
// Ports: clk, reset_n (async low), flush, in_if (byte-lane stream, slave),
//   array_ready, weight_in/weight_en/weight_ctr/tile_done to the arranger,
//   buf_count (full buffers). Macro WTL_TRANSPOSE_EN: store stream byte
//   r*N+c at tile position c*N+r (column-major source to row-major tile).
module weight_tile_loader #(
    parameter int N         = 4,
    parameter int BUS_BYTES = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                flush,
    weight_tile_loader_if.slave in_if,
    input  logic                array_ready,
    output logic [8*N*N-1:0]    weight_in,
    output logic                weight_en,
    output logic                weight_ctr,
    output logic                tile_done,
    output logic [1:0]          buf_count
);
    localparam int TB    = N * N;
    localparam int TW    = 8 * TB;
    localparam int BEATS = TB / BUS_BYTES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CW    = (N > 1) ? $clog2(N) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [CW-1:0] LAST_COL  = CW'(N - 1);

    if ((TB % BUS_BYTES) != 0) begin : g_bad_bus
        $error("N*N must be a multiple of BUS_BYTES");
    end

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STREAM
    } state_t;

    function automatic int tile_pos(input int s);
`ifdef WTL_TRANSPOSE_EN
        return (s % N) * N + s / N;
`else
        return s;
`endif
    endfunction

    state_t             state_q, state_d;
    logic [1:0][TW-1:0] buf_q, buf_d;
    logic [1:0]         full_q, full_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [BW-1:0]      beat_q, beat_d;
    logic [CW-1:0]      col_q, col_d;
    logic [TW-1:0]      win_q, win_d;
    logic               accept;

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        full_d   = full_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        beat_d   = beat_q;
        col_d    = col_q;
        win_d    = win_q;
        accept   = in_if.in_valid && !full_q[wr_ptr_q];

        // weight_in is captured on entry to LOAD so it is valid
        // during the weight_en cycle itself.
        unique case (state_q)
            IDLE: begin
                if (full_q[rd_ptr_q] && array_ready) begin
                    state_d = LOAD;
                    win_d   = buf_q[rd_ptr_q];
                end
            end
            LOAD: begin
                full_d[rd_ptr_q] = 1'b0;
                rd_ptr_d         = !rd_ptr_q;
                col_d            = '0;
                state_d          = STREAM;
            end
            STREAM: begin
                col_d = col_q + 1'b1;
                if (col_q == LAST_COL) begin
                    if (full_q[rd_ptr_q] && array_ready) begin
                        state_d = LOAD;
                        win_d   = buf_q[rd_ptr_q];
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // The write buffer is never the one being released in LOAD,
        // so fill-side completion and LOAD release never collide.
        if (accept) begin
            for (int j = 0; j < BUS_BYTES; j++) begin
                buf_d[wr_ptr_q][8*tile_pos(int'(beat_q)*BUS_BYTES + j) +: 8] =
                    in_if.in_data[8*j +: 8];
            end
            if (beat_q == LAST_BEAT) begin
                full_d[wr_ptr_q] = 1'b1;
                wr_ptr_d         = !wr_ptr_q;
                beat_d           = '0;
            end else begin
                beat_d = beat_q + 1'b1;
            end
        end

        if (flush) begin
            state_d  = IDLE;
            full_d   = '0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            beat_d   = '0;
            col_d    = '0;
            win_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            buf_q    <= '0;
            full_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            beat_q   <= '0;
            col_q    <= '0;
            win_q    <= '0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            full_q   <= full_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            beat_q   <= beat_d;
            col_q    <= col_d;
            win_q    <= win_d;
        end
    end

    assign in_if.in_ready = !full_q[wr_ptr_q];
    assign weight_in      = win_q;
    assign weight_en      = (state_q == LOAD);
    assign weight_ctr     = (state_q == STREAM);
    assign tile_done      = (state_q == STREAM) && (col_q == LAST_COL);
    assign buf_count      = {1'b0, full_q[0]} + {1'b0, full_q[1]};
endmodule

// File: tb/tb_weight_tile_loader.sv
// Bench for weight_tile_loader: tile-level reference model plus
// directed and randomized stimulus.
module tb_weight_tile_loader;
    localparam int N         = 4;
    localparam int BUS_BYTES = 4;
    localparam int TB        = N * N;
    localparam int TW        = 8 * TB;
    localparam int BEATS     = TB / BUS_BYTES;
    localparam int DW        = 8 * BUS_BYTES;

`ifdef WTL_TRANSPOSE_EN
    localparam logic [TW-1:0] EXP_INC  = 128'h0F0B07030E0A06020D0905010C080400;
    localparam logic [TW-1:0] EXP_INC2 = 128'h1F1B17131E1A16121D1915111C181410;
`else
    localparam logic [TW-1:0] EXP_INC  = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [TW-1:0] EXP_INC2 = 128'h1F1E1D1C1B1A19181716151413121110;
`endif

    logic          clk         = 1'b0;
    logic          reset_n     = 1'b0;
    logic          flush       = 1'b0;
    logic          array_ready = 1'b0;
    logic [TW-1:0] weight_in;
    logic          weight_en;
    logic          weight_ctr;
    logic          tile_done;
    logic [1:0]    buf_count;

    weight_tile_loader_if #(.BUS_BYTES(BUS_BYTES)) bus ();

    weight_tile_loader #(
        .N(N),
        .BUS_BYTES(BUS_BYTES)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .in_if      (bus),
        .array_ready(array_ready),
        .weight_in  (weight_in),
        .weight_en  (weight_en),
        .weight_ctr (weight_ctr),
        .tile_done  (tile_done),
        .buf_count  (buf_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;
    int b2b    = 0;
    bit prev_done = 1'b0;

    task automatic chk(input string nm, input logic [TW-1:0] act,
                       input logic [TW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int pos(input int s);
`ifdef WTL_TRANSPOSE_EN
        return (s % N) * N + s / N;
`else
        return s;
`endif
    endfunction

    function automatic logic [TW-1:0] arrange(input logic [TW-1:0] t);
        logic [TW-1:0] r;
        r = '0;
        for (int s = 0; s < TB; s++) r[8*pos(s) +: 8] = t[8*s +: 8];
        return r;
    endfunction

    // Reference model: queue of complete tiles awaiting drain,
    // partially assembled tile, and drain phase
    // (0 idle, 1 load, 2..N+1 column stream).
    logic [TW-1:0] mq[$];
    logic [TW-1:0] mpart;
    logic [TW-1:0] mcur;
    int            mbytes;
    int            mphase;

    task automatic m_reset();
        mq.delete();
        mpart  = '0;
        mcur   = '0;
        mbytes = 0;
        mphase = 0;
    endtask

    task automatic m_step();
        bit acc;
        if (flush) begin
            m_reset();
            return;
        end
        acc = bus.in_valid && (mq.size() < 2);
        if (mphase == 0 || mphase == N + 1) begin
            if (mq.size() > 0 && array_ready) begin
                mphase = 1;
                mcur   = mq[0];
            end else begin
                mphase = 0;
            end
        end else if (mphase == 1) begin
            void'(mq.pop_front());
            mphase = 2;
        end else begin
            mphase++;
        end
        if (acc) begin
            for (int j = 0; j < BUS_BYTES; j++)
                mpart[8*pos(mbytes + j) +: 8] = bus.in_data[8*j +: 8];
            mbytes += BUS_BYTES;
            if (mbytes == TB) begin
                mq.push_back(mpart);
                mbytes = 0;
            end
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) m_reset();
            else m_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_on) begin
                chk("in_ready", bus.in_ready, mq.size() < 2);
                chk("buf_count", buf_count, mq.size());
                chk("weight_en", weight_en, mphase == 1);
                chk("weight_ctr", weight_ctr, mphase >= 2);
                chk("tile_done", tile_done, mphase == N + 1);
                chk("weight_in", weight_in, mcur);
            end
            if (weight_en && prev_done) b2b++;
            prev_done = tile_done;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: sim time expired, got timeout required finish");
        $fatal(1);
    end

    task automatic send_beat(input logic [DW-1:0] d);
        int n;
        bit acc;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        do begin
            acc = bus.in_ready;
            @(negedge clk);
            n++;
        end while (!acc && n < 200);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: in_ready got 0 required 1");
        end
    endtask

    task automatic send_tile(input logic [TW-1:0] t);
        for (int k = 0; k < BEATS; k++) send_beat(t[DW*k +: DW]);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_en(output int n);
        n = 0;
        while (!weight_en && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!weight_en) begin
            checks++;
            errors++;
            $display("FAIL en_timeout: weight_en got 0 required 1");
        end
    endtask

    task automatic test_single(input logic [TW-1:0] t,
                               input logic [TW-1:0] exp);
        int n, ctr, done, en;
        array_ready = 1'b1;
        send_tile(t);
        wait_en(n);
        chk("load_latency", n, 1);
        chk("tile_load", weight_in, exp);
        ctr  = 0;
        done = 0;
        en   = 0;
        repeat (8) begin
            @(negedge clk);
            ctr  += int'(weight_ctr);
            done += int'(tile_done);
            en   += int'(weight_en);
        end
        chk("ctr_cycles", ctr, 4);
        chk("tile_done_cnt", done, 1);
        chk("en_single", en, 0);
        chk("buf_empty", buf_count, 0);
    endtask

    logic [TW-1:0] inc, inc2, ta, tb;
    int n, b0, e1, e2, ne;

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        for (int i = 0; i < TB; i++) begin
            inc[8*i +: 8]  = 8'(i);
            inc2[8*i +: 8] = 8'(i + 16);
        end

        repeat (3) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_weight_in", weight_in, 0);
        chk("rst_weight_en", weight_en, 0);
        chk("rst_weight_ctr", weight_ctr, 0);
        chk("rst_tile_done", tile_done, 0);
        chk("rst_buf_count", buf_count, 0);
        reset_n = 1'b1;
        cmp_on  = 1'b1;
        @(negedge clk);

        test_single(inc, EXP_INC);
`ifdef WTL_TRANSPOSE_EN
        chk("xpose_pos1", weight_in[15:8], 8'h04);
        chk("xpose_pos4", weight_in[39:32], 8'h01);
`endif

        array_ready = 1'b0;
        for (int k = 0; k < 2 * BEATS; k++) send_beat(DW'($urandom));
        bus.in_valid = 1'b1;
        bus.in_data  = DW'($urandom);
        repeat (3) @(negedge clk);
        chk("bp_buf_count", buf_count, 2);
        chk("bp_in_ready", bus.in_ready, 0);
        bus.in_valid = 1'b0;
        b0 = b2b;
        array_ready = 1'b1;
        e1 = -1;
        e2 = -1;
        ne = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (weight_en) begin
                if (ne == 0) e1 = c;
                else if (ne == 1) e2 = c;
                ne++;
            end
        end
        chk("bp_en_pulses", ne, 2);
        chk("bp_en_spacing", e2 - e1, 5);
        chk("bp_b2b", b2b - b0, 1);
        chk("bp_drained", buf_count, 0);

        for (int i = 0; i < TB / 4; i++) begin
            ta[32*i +: 32] = $urandom;
            tb[32*i +: 32] = $urandom;
        end
        b0 = b2b;
        send_tile(ta);
        send_tile(tb);
        repeat (20) @(negedge clk);
        chk("ovl_b2b", b2b - b0, 1);
        chk("ovl_last_tile", weight_in, arrange(tb));

        send_beat(32'hAAAA_AAAA);
        send_beat(32'hBBBB_BBBB);
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_weight_in", weight_in, 0);
        chk("flush_buf", buf_count, 0);
        test_single(inc2, EXP_INC2);

        send_tile(ta);
        wait_en(n);
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_ctr", weight_ctr, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_weight_ctr", weight_ctr, 0);
        chk("arst_weight_en", weight_en, 0);
        chk("arst_tile_done", tile_done, 0);
        chk("arst_buf_count", buf_count, 0);
        chk("arst_in_ready", bus.in_ready, 1);
        chk("arst_weight_in", weight_in, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        test_single(inc, EXP_INC);

        for (int c = 0; c < 400; c++) begin
            flush        = ($urandom_range(0, 39) == 0);
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_data  = DW'($urandom);
            array_ready  = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        array_ready  = 1'b1;
        repeat (30) @(negedge clk);
        chk("final_buf", buf_count, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
